// File: rtl/lcz80_regbank.sv
// Banked Z80-style register file with main/alternate banks, mask-driven swaps,
// three read ports, split write port and a one-cycle pair inc/dec engine.
module lcz80_regbank #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int BYPASS = 1,
  parameter logic [(1<<AW)-1:0] SWAP0_MASK = 'h07,
  parameter logic [(1<<AW)-1:0] SWAP1_MASK = '0,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b1}}
) (
  input  logic                 clk,
  input  logic                 RESET_n,
  input  logic                 CEN,
  input  logic [AW-1:0]        AddrA,
  input  logic [AW-1:0]        AddrB,
  input  logic [AW-1:0]        AddrC,
  input  logic [DW-1:0]        DIH,
  input  logic [DW-1:0]        DIL,
  input  logic                 WEH,
  input  logic                 WEL,
  output logic [DW-1:0]        DOAH,
  output logic [DW-1:0]        DOAL,
  output logic [DW-1:0]        DOBH,
  output logic [DW-1:0]        DOBL,
  output logic [DW-1:0]        DOCH,
  output logic [DW-1:0]        DOCL,
  input  logic                 swap0,
  input  logic                 swap1,
  input  logic                 inc_req,
  input  logic                 inc_dec,
  input  logic [AW-1:0]        inc_addr,
  output logic                 inc_zero,
  output logic                 inc_lost,
  output logic [(1<<AW)-1:0]   bank_o
);

  localparam int NREG = 1 << AW;
  localparam int PW = 2 * DW;
  localparam logic BYP = (BYPASS != 0);

  logic [DW-1:0]   h_q [2][NREG];
  logic [DW-1:0]   h_d [2][NREG];
  logic [DW-1:0]   l_q [2][NREG];
  logic [DW-1:0]   l_d [2][NREG];
  logic [NREG-1:0] bank_q, bank_d;
  logic            zero_q, zero_d;
  logic            lost_q, lost_d;

  logic            byp_h, byp_l;
  logic            sel_a, sel_b, sel_c, sel_i;
  logic            conflict;
  logic [PW-1:0]   pair_cur;
  logic [PW-1:0]   inc_res;

  assign sel_a = bank_q[AddrA];
  assign sel_b = bank_q[AddrB];
  assign sel_c = bank_q[AddrC];
  assign sel_i = bank_q[inc_addr];

  assign byp_h = BYP & CEN & WEH;
  assign byp_l = BYP & CEN & WEL;

  always_comb begin
    DOAH = byp_h ? DIH : h_q[sel_a][AddrA];
    DOAL = byp_l ? DIL : l_q[sel_a][AddrA];
    DOBH = (byp_h && AddrB == AddrA) ? DIH : h_q[sel_b][AddrB];
    DOBL = (byp_l && AddrB == AddrA) ? DIL : l_q[sel_b][AddrB];
    DOCH = (byp_h && AddrC == AddrA) ? DIH : h_q[sel_c][AddrC];
    DOCL = (byp_l && AddrC == AddrA) ? DIL : l_q[sel_c][AddrC];
  end

  // The write port owns the whole pair on a clash, even its unwritten half.
  assign conflict = inc_req & (WEH | WEL) & (inc_addr == AddrA);

  assign pair_cur = {h_q[sel_i][inc_addr], l_q[sel_i][inc_addr]};
  assign inc_res  = inc_dec ? pair_cur - PW'(1) : pair_cur + PW'(1);

  always_comb begin
    h_d    = h_q;
    l_d    = l_q;
    bank_d = bank_q;
    zero_d = zero_q;
    lost_d = lost_q;
    if (CEN) begin
      if (WEH) h_d[sel_a][AddrA] = DIH;
      if (WEL) l_d[sel_a][AddrA] = DIL;
      if (inc_req && !conflict) begin
        h_d[sel_i][inc_addr] = inc_res[PW-1:DW];
        l_d[sel_i][inc_addr] = inc_res[DW-1:0];
        zero_d = (inc_res == '0);
      end
      lost_d = conflict;
      bank_d = bank_q
             ^ ({NREG{swap0}} & SWAP0_MASK)
             ^ ({NREG{swap1}} & SWAP1_MASK);
    end
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NREG; i++) begin
          h_q[b][i] <= RST_VAL;
          l_q[b][i] <= RST_VAL;
        end
      end
      bank_q <= '0;
      zero_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      l_q    <= l_d;
      bank_q <= bank_d;
      zero_q <= zero_d;
      lost_q <= lost_d;
    end
  end

  assign inc_zero = zero_q;
  assign inc_lost = lost_q;
  assign bank_o   = bank_q;

endmodule

// File: tb/tb_lcz80_regbank.sv
// Randomised bench for lcz80_regbank: two instances (bypass / no bypass)
// checked against a pair-level reference model.
module tb_lcz80_regbank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen, weh, wel, swap0, swap1, inc_req, inc_dec;
  logic [2:0] addra, addrb, addrc, inc_addr;
  logic [7:0] dih, dil;

  logic [7:0] doh [2][3];
  logic [7:0] dol [2][3];
  logic [7:0] bank_o [2];
  logic       izero [2];
  logic       ilost [2];

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] mp [2][2][8];
  logic [7:0]  mb [2];
  logic        mz [2];
  logic        ml [2];
  logic [7:0]  m0 [2];
  logic [7:0]  m1 [2];

  always #5 clk = ~clk;

  lcz80_regbank #(
    .DW(8), .AW(3), .BYPASS(1),
    .SWAP0_MASK(8'h07), .SWAP1_MASK(8'h81), .RST_VAL(8'hFF)
  ) u_byp (
    .clk(clk), .RESET_n(rst_n), .CEN(cen),
    .AddrA(addra), .AddrB(addrb), .AddrC(addrc),
    .DIH(dih), .DIL(dil), .WEH(weh), .WEL(wel),
    .DOAH(doh[0][0]), .DOAL(dol[0][0]),
    .DOBH(doh[0][1]), .DOBL(dol[0][1]),
    .DOCH(doh[0][2]), .DOCL(dol[0][2]),
    .swap0(swap0), .swap1(swap1),
    .inc_req(inc_req), .inc_dec(inc_dec), .inc_addr(inc_addr),
    .inc_zero(izero[0]), .inc_lost(ilost[0]), .bank_o(bank_o[0])
  );

  lcz80_regbank #(
    .DW(8), .AW(3), .BYPASS(0),
    .SWAP0_MASK(8'h07), .SWAP1_MASK(8'h00), .RST_VAL(8'hFF)
  ) u_nb (
    .clk(clk), .RESET_n(rst_n), .CEN(cen),
    .AddrA(addra), .AddrB(addrb), .AddrC(addrc),
    .DIH(dih), .DIL(dil), .WEH(weh), .WEL(wel),
    .DOAH(doh[1][0]), .DOAL(dol[1][0]),
    .DOBH(doh[1][1]), .DOBL(dol[1][1]),
    .DOCH(doh[1][2]), .DOCL(dol[1][2]),
    .swap0(swap0), .swap1(swap1),
    .inc_req(inc_req), .inc_dec(inc_dec), .inc_addr(inc_addr),
    .inc_zero(izero[1]), .inc_lost(ilost[1]), .bank_o(bank_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++) mp[n][b][i] = 16'hFFFF;
      mb[n] = '0;
      mz[n] = 1'b0;
      ml[n] = 1'b0;
    end
  endtask

  function automatic logic [15:0] mread(int n, logic [2:0] a);
    logic [15:0] v;
    v = mp[n][mb[n][a]][a];
    if (n == 0 && cen && weh && a == addra) v[15:8] = dih;
    if (n == 0 && cen && wel && a == addra) v[7:0] = dil;
    return v;
  endfunction

  task automatic model_step();
    logic conf, ba, bi;
    logic [15:0] v;
    for (int n = 0; n < 2; n++) begin
      if (cen) begin
        conf = inc_req && (weh || wel) && inc_addr == addra;
        ba = mb[n][addra];
        bi = mb[n][inc_addr];
        v = mp[n][ba][addra];
        if (weh) v[15:8] = dih;
        if (wel) v[7:0] = dil;
        mp[n][ba][addra] = v;
        if (inc_req && !conf) begin
          v = mp[n][bi][inc_addr];
          v = inc_dec ? v - 16'd1 : v + 16'd1;
          mp[n][bi][inc_addr] = v;
          mz[n] = (v == 16'd0);
        end
        ml[n] = conf;
        mb[n] = mb[n] ^ ({8{swap0}} & m0[n]) ^ ({8{swap1}} & m1[n]);
      end
    end
  endtask

  task automatic check_reads();
    logic [2:0] a;
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < 3; p++) begin
        a = (p == 0) ? addra : (p == 1) ? addrb : addrc;
        chk($sformatf("rd%0d%0d", n, p), {doh[n][p], dol[n][p]}, mread(n, a));
      end
  endtask

  task automatic tick();
    #1 check_reads();
    @(posedge clk);
    model_step();
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("bank%0d", n), bank_o[n], mb[n]);
      chk($sformatf("zero%0d", n), izero[n], mz[n]);
      chk($sformatf("lost%0d", n), ilost[n], ml[n]);
    end
    @(negedge clk);
  endtask

  task automatic clear();
    cen = 1'b1; weh = 1'b0; wel = 1'b0; swap0 = 1'b0; swap1 = 1'b0;
    inc_req = 1'b0; inc_dec = 1'b0;
    addra = '0; addrb = '0; addrc = '0; inc_addr = '0;
    dih = '0; dil = '0;
  endtask

  initial begin
    m0[0] = 8'h07; m1[0] = 8'h81;
    m0[1] = 8'h07; m1[1] = 8'h00;
    clear();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      addrb = 3'(i);
      #1 chk("rst_rd", {doh[0][1], dol[0][1]}, 16'hFFFF);
    end
    chk("rst_bank", bank_o[0], 8'h00);
    rst_n = 1'b1;
    addrb = '0;
    tick();

    // reset asserted in the middle of a write
    addra = 3'd3; weh = 1'b1; dih = 8'h12;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear();
    rst_n = 1'b1;
    model_reset();
    addrb = 3'd3;
    #1 chk("rst_wr", {doh[0][1], dol[0][1]}, 16'hFFFF);
    tick();

    clear();
    addra = 3'd2; addrb = 3'd2; weh = 1'b1; wel = 1'b1;
    dih = 8'hAB; dil = 8'hCD;
    #1 chk("byp_same", {doh[0][1], dol[0][1]}, 16'hABCD);
    chk("nb_same", {doh[1][1], dol[1][1]}, 16'hFFFF);
    tick();
    clear(); addrb = 3'd2;
    #1 chk("nb_next", {doh[1][1], dol[1][1]}, 16'hABCD);
    tick();

    clear(); inc_req = 1'b1; inc_addr = 3'd0;
    tick();
    clear();
    #1 chk("inc_wrap", {doh[0][0], dol[0][0]}, 16'h0000);
    chk("inc_zero", izero[0], 1'b1);
    inc_req = 1'b1; inc_dec = 1'b1;
    tick();
    clear();
    #1 chk("dec_wrap", {doh[0][0], dol[0][0]}, 16'hFFFF);
    chk("dec_zero", izero[0], 1'b0);

    clear(); addra = 3'd4; weh = 1'b1; wel = 1'b1; dih = 8'h01; dil = 8'h00;
    tick();
    clear(); addra = 3'd4; wel = 1'b1; dil = 8'h55;
    inc_req = 1'b1; inc_addr = 3'd4;
    tick();
    chk("lost_pulse", ilost[0], 1'b1);
    clear(); addra = 3'd4;
    #1 chk("conf_pair", {doh[0][0], dol[0][0]}, 16'h0155);
    tick();
    chk("lost_clr", ilost[0], 1'b0);

    clear(); addra = 3'd1; weh = 1'b1; wel = 1'b1; dih = 8'h12; dil = 8'h34;
    tick();
    clear(); swap0 = 1'b1;
    tick();
    clear(); addra = 3'd1; weh = 1'b1; wel = 1'b1; dih = 8'h56; dil = 8'h78;
    tick();
    clear(); swap0 = 1'b1;
    tick();
    clear(); addra = 3'd1;
    #1 chk("swap_rd", {doh[0][0], dol[0][0]}, 16'h1234);
    chk("swap_bank", bank_o[0], 8'h00);
    swap0 = 1'b1; swap1 = 1'b1;
    tick();
    chk("dual_swap", bank_o[0], 8'h86);

    clear(); addra = 3'd6; weh = 1'b1; dih = 8'h00;
    inc_req = 1'b1; inc_addr = 3'd6;
    tick();
    clear(); cen = 1'b0; addra = 3'd5; weh = 1'b1; dih = 8'h99;
    swap0 = 1'b1; inc_req = 1'b1; inc_addr = 3'd5;
    tick();
    chk("cen_bank", bank_o[0], 8'h86);
    chk("cen_lost", ilost[0], 1'b1);
    clear(); addra = 3'd5;
    #1 chk("cen_reg", {doh[0][0], dol[0][0]}, 16'hFFFF);

    for (int k = 0; k < 1500; k++) begin
      cen = ($urandom_range(7) != 0);
      weh = ($urandom_range(3) == 0);
      wel = ($urandom_range(3) == 0);
      swap0 = ($urandom_range(5) == 0);
      swap1 = ($urandom_range(5) == 0);
      inc_req = ($urandom_range(1) == 0);
      inc_dec = $urandom_range(1) != 0;
      addra = 3'($urandom_range(7));
      addrb = 3'($urandom_range(7));
      addrc = ($urandom_range(3) == 0) ? addra : 3'($urandom_range(7));
      inc_addr = ($urandom_range(3) == 0) ? addra : 3'($urandom_range(7));
      dih = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      dil = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(15) == 0) begin
        dih = 8'h00; dil = 8'h00;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcz80_regbank.md
Name: lcz80_regbank

Overview:
- Parametrised successor to the Z80 core register file.
- Holds 2^AW register pairs in two physical banks (main/alternate).
- Per-index bank selects are toggled by two mask-driven swap commands (EXX-style and EX-style).
- Provides three combinational read ports, one split high/low write port, and a one-cycle 16-bit pair increment/decrement engine (INC rr/DEC rr, block-op pointers).

Parameters:
- DW, 8, width of each half register; a pair is 2*DW bits.
- AW, 3, address width; NREG = 2^AW pair indices.
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = read ports show stored contents only.
- SWAP0_MASK, 8'h07, indices toggled by swap0 (EXX: BC, DE, HL); width NREG.
- SWAP1_MASK, 8'h00, indices toggled by swap1; width NREG.
- RST_VAL, {DW{1'b1}}, reset value of every half register in both banks.

Ports:
- clk  in  1  clock, rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- CEN  in  1  clock enable; gates all state updates.
- AddrA  in  AW  write address and read port A.
- AddrB  in  AW  read port B.
- AddrC  in  AW  read port C.
- DIH  in  DW  write data, high half.
- DIL  in  DW  write data, low half.
- WEH  in  1  write enable, high half.
- WEL  in  1  write enable, low half.
- DOAH, DOAL, DOBH, DOBL, DOCH, DOCL  out  DW each  read data.
- swap0  in  1  toggle bank_sel for indices in SWAP0_MASK.
- swap1  in  1  toggle bank_sel for indices in SWAP1_MASK.
- inc_req  in  1  pair inc/dec request.
- inc_dec  in  1  0 = +1, 1 = -1.
- inc_addr  in  AW  pair index for inc/dec.
- inc_zero  out  1  registered; 1 when the last completed inc/dec result was 0.
- inc_lost  out  1  registered one-cycle pulse; inc/dec was dropped due to a write conflict.
- bank_o  out  NREG  current bank_sel vector.

Behaviour:
- Reset (RESET_n low, asynchronous):
  - All halves in both banks = RST_VAL; bank_sel = 0; inc_zero = 0; inc_lost = 0.
  - DO* therefore read RST_VAL.
  - Reset is effective mid-operation: any in-flight write, swap or inc is discarded.
- Addressing: logical index i maps to physical bank bank_sel[i]. All ports (A, B, C, inc) use the pre-edge bank_sel.
- Write: at posedge when CEN=1:
  - WEH writes DIH to the high half of bank[bank_sel[AddrA]][AddrA].
  - WEL writes DIL to the low half. Halves are independent.
- Read: combinational from the current bank.
  - If BYPASS=1 and CEN & WEH & (AddrX == AddrA), then DOXH = DIH; likewise WEL/DOXL.
  - If BYPASS=0, reads show the stored value; new data is visible the cycle after the edge.
- Swap: at posedge when CEN=1:
  - bank_sel[i] ^= (swap0 & SWAP0_MASK[i]) ^ (swap1 & SWAP1_MASK[i]).
  - Both swaps hitting the same index in one cycle leave it unchanged.
  - A write in the same cycle as a swap lands in the pre-swap bank.
- Inc/dec: at posedge when CEN & inc_req:
  - pair[inc_addr] <= {H,L} ± 1, modulo 2^(2*DW). 16'hFFFF+1 -> 0000; 0000-1 -> FFFF.
  - inc_zero <= (result == 0). Latency 1; result readable the next cycle. No bypass of inc results.
- Conflict: inc_req & (WEH|WEL) & (inc_addr == AddrA) & CEN:
  - The write port wins for the whole pair (an unwritten half is also untouched).
  - The inc is dropped: inc_lost = 1 next cycle; inc_zero holds.
- inc_lost is 0 in every other cycle. When CEN=0, inc_lost and inc_zero hold their values and no state changes.
- Simultaneous swap + inc on the same index: the inc uses the pre-swap bank.

Test Plan:
- Reset release -> all DO* = 8'hFF, bank_o = 0; assert RESET_n low mid-write with WEH=1, DIH=8'h12 -> reg stays 8'hFF.
- Write AddrA=2, DIH=8'hAB, DIL=8'hCD with AddrB=2:
  - BYPASS=1 -> DOBH/DOBL = AB/CD in the same cycle.
  - BYPASS=0 -> AB/CD appear on the following cycle only.
- Write pair 1 = 1234, swap0, write pair 1 = 5678, swap0 -> DOA (AddrA=1) reads 1234, bank_o = 0.
  - swap0 and swap1 together with index 0 in both masks -> bank_sel[0] unchanged.
- inc_addr=0 with pair = FFFF, inc_dec=0 -> next cycle 0000, inc_zero = 1.
  - Then inc_dec=1 -> FFFF, inc_zero = 0.
- inc_req on index 4 with WEL=1, AddrA=4, DIL=8'h55, pair = 0100 -> pair = 0155, inc_lost pulses 1 for exactly one cycle.
- CEN=0 with WEH, swap0 and inc_req all asserted -> no register, bank_o, inc_zero or inc_lost change.
